decoder_3x8_hold: RTL
=====================

// Module: decoder_3x8_hold
// PURPOSE
//  - Registered 3-to-8 binary-to-one-hot decoder; inverse of the 8x3 one-hot encoder.
//  - Accepts a 3-bit code over valid/ready and drives one-hot Y[7:0] for exactly HOLD_CYCLES cycles, then releases.
//  - Sits between command/select logic and one-hot consumers: strobes, mux selects, LED/row drivers.
// PARAMETERS
//  - HOLD_CYCLES  default 4  cycles Y stays asserted per accepted code; legal range 1..255.
//  - OUT_POL      default 1  1: active-high one-hot (idle 8'h00); 0: active-low one-cold (idle 8'hFF).
// PORTS
//  - clk       in   1  single clock; all logic on rising edge.
//  - rst_n     in   1  reset, asynchronous assert, active-low.
//  - in_valid  in   1  in_code valid.
//  - in_ready  out  1  block can accept in_code this cycle.
//  - in_code   in   3  binary code 0..7.
//  - abort     in   1  synchronous flush of the current hold window.
//  - Y         out  8  registered one-hot (polarity per OUT_POL).
//  - busy      out  1  1 while a hold window is active.
//  - done      out  1  1-cycle pulse in the final cycle of each completed hold window.
//  - in_par    in   1  (DEC_PARITY_EN only) even-parity bit over in_code.
//  - err       out  1  (DEC_PARITY_EN only) 1-cycle pulse on parity reject.
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, cnt=0, Y=idle value, busy=0, done=0, err=0. Takes effect mid-window with no completion pulse.
//  - FSM states: IDLE, HOLD.
//  - Transfer occurs when in_valid & in_ready at a rising edge.
//  - in_ready = !abort & (state==IDLE | (state==HOLD & cnt==1)). Combinational from registers and abort only; no dependence on in_valid.
//  - IDLE --transfer--> HOLD:
//    - next cycle Y = 1<<in_code (inverted if OUT_POL=0), cnt = HOLD_CYCLES, busy=1.
//    - latency: code to Y is 1 cycle.
//  - In HOLD, cnt decrements each cycle. When cnt==1: done=1 in that cycle.
//    - With a transfer in the same cycle: reload Y/cnt and stay in HOLD. No idle gap; back-to-back windows abut.
//    - Without a transfer: next cycle Y=idle, busy=0, state=IDLE.
//  - Y is asserted for exactly HOLD_CYCLES consecutive cycles per transfer. HOLD_CYCLES=1 gives a single-cycle strobe and in_ready held high.
//  - abort=1 (any state):
//    - next cycle Y=idle, busy=0, cnt=0, state=IDLE; no done pulse.
//    - abort dominates in_valid because in_ready is forced 0.
//  - Y is never multi-hot. At most one bit differs from the idle value in any cycle.
//  - cnt width: 8 bits, unsigned; never wraps (reload or exit at 1).
// CONFIGURATION
//  - Macro DEC_PARITY_EN.
//  - Defined:
//    - in_par and err ports present.
//    - A transfer with ^{in_code,in_par}==1 completes the handshake but is rejected.
//    - On reject: err=1 next cycle, Y/busy/cnt/state unchanged; an active window continues and done still fires.
//  - Undefined:
//    - in_par and err ports absent.
//    - Every transfer is decoded.
// STRUCTURE
//  - Package decoder_3x8_pkg:
//    - typedef enum logic {IDLE,HOLD} dec_state_t
//    - localparam CNT_W=8
//    - function onehot8(logic [2:0]) returns logic [7:0]
//  - Sub-module decoder_3x8_core: pure combinational code -> one-hot with polarity. Wrapper holds FSM, counter and registers.
// TESTING
//  - Reset, HOLD_CYCLES=4: rst_n low 3 cycles -> Y=8'h00, busy=0, in_ready=1; after release, no activity with in_valid=0.
//  - Sweep: send codes 0..7 singly with gaps -> each Y=8'h01,8'h02,...,8'h80 for exactly 4 cycles, 1-cycle latency, done in 4th cycle.
//  - Back-to-back: code 3, then code 6 held valid -> accepted at cnt==1; Y=8'h08 x4 then 8'h40 x4, no 8'h00 gap.
//  - Abort: code 5, abort in 2nd hold cycle -> Y=8'h00 next cycle, no done; in_valid with abort=1 -> not accepted.
//  - Mid-window async reset: code 7, rst_n low in cycle 2 -> Y=8'h00 immediately, busy=0, no done.
//  - DEC_PARITY_EN: code 3 (3'b011) with in_par=1 -> err pulse, Y stays 8'h00; with in_par=0 -> Y=8'h08 for 4 cycles.
//    Also run with OUT_POL=0: code 0 -> Y=8'hFE.

Source files
------------

// File: rtl/decoder_3x8_pkg.sv
// Shared types and helpers for the registered 3-to-8 hold decoder.
package decoder_3x8_pkg;

  typedef enum logic {IDLE, HOLD} dec_state_t;

  localparam int unsigned CNT_W = 8;

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    logic [7:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_3x8_core.sv
// Combinational 3-bit code to one-hot (OUT_POL=1) or one-cold (OUT_POL=0).
module decoder_3x8_core
  import decoder_3x8_pkg::*;
#(
  parameter bit OUT_POL = 1'b1
) (
  input  logic [2:0] code,
  output logic [7:0] y
);

  always_comb begin
    y = OUT_POL ? onehot8(code) : ~onehot8(code);
  end

endmodule

// File: rtl/decoder_3x8_hold.sv
// Registered 3-to-8 decoder holding each accepted code for HOLD_CYCLES cycles.
// Optional parity check on in_code enabled by macro DEC_PARITY_EN.
module decoder_3x8_hold
  import decoder_3x8_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter bit          OUT_POL     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       abort,
`ifdef DEC_PARITY_EN
  input  logic       in_par,
  output logic       err,
`endif
  output logic [7:0] Y,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0]       Y_IDLE   = OUT_POL ? 8'h00 : 8'hFF;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dec_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       y_q, y_d;
  logic [7:0]       y_dec;
  logic             xfer;
  logic             par_ok;
  logic             last_cycle;

  decoder_3x8_core #(.OUT_POL(OUT_POL)) u_core (
    .code (in_code),
    .y    (y_dec)
  );

`ifdef DEC_PARITY_EN
  logic err_q, err_d;
  assign par_ok = ~(^{in_code, in_par});
  assign err    = err_q;
`else
  assign par_ok = 1'b1;
`endif

  assign last_cycle = (state_q == HOLD) && (cnt_q == CNT_ONE);
  assign xfer       = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= Y_IDLE;
`ifdef DEC_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
`ifdef DEC_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

  // A parity-rejected transfer behaves like no transfer: the window runs on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      y_d     = Y_IDLE;
    end else if (xfer && par_ok) begin
      state_d = HOLD;
      cnt_d   = CNT_LOAD;
      y_d     = y_dec;
    end else if (state_q == HOLD) begin
      if (cnt_q == CNT_ONE) begin
        state_d = IDLE;
        cnt_d   = '0;
        y_d     = Y_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
`ifdef DEC_PARITY_EN
    err_d = xfer && !par_ok;
`endif
  end

  always_comb begin
    in_ready = !abort && ((state_q == IDLE) || last_cycle);
    done     = last_cycle && !abort;
    busy     = (state_q == HOLD);
    Y        = y_q;
  end

endmodule
